// File: rtl/fifo_resultados_ctrl_if.sv
// rtl/fifo_resultados_ctrl_if.sv - result-FIFO write sequencer bus bundle
// Optional FIFO_RES_OVF_COUNT_EN adds the drop_cnt status field.
interface fifo_resultados_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 14
);
  logic [DATA_W-1:0] src_data;
  logic              src_valid;
  logic              start;
  logic              abort;
  logic [CNT_W-1:0]  frame_len;
  logic              host_rd;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_wrreq;
  logic              fifo_rdreq;
  logic              busy;
  logic              frame_ready;
  logic [CNT_W-1:0]  level;
  logic              dropped;
`ifdef FIFO_RES_OVF_COUNT_EN
  logic [15:0]       drop_cnt;
`endif

  modport master (
    output src_data, src_valid, start, abort, frame_len, host_rd,
    input  fifo_data, fifo_wrreq, fifo_rdreq, busy, frame_ready, level, dropped
`ifdef FIFO_RES_OVF_COUNT_EN
    , input drop_cnt
`endif
  );

  modport slave (
    input  src_data, src_valid, start, abort, frame_len, host_rd,
    output fifo_data, fifo_wrreq, fifo_rdreq, busy, frame_ready, level, dropped
`ifdef FIFO_RES_OVF_COUNT_EN
    , output drop_cnt
`endif
  );
endinterface

// File: rtl/fifo_resultados_ctrl.sv
// rtl/fifo_resultados_ctrl.sv - write-side sequencer and occupancy mirror for the results scfifo
// Optional FIFO_RES_OVF_COUNT_EN adds a saturating count of refused words (drop_cnt).
module fifo_resultados_ctrl #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8192,
  parameter int CNT_W  = 14
) (
  input  logic                   i_wrclock,
  input  logic                   i_reset_n,
  fifo_resultados_ctrl_if.slave  io_bus
);
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_READY   = 2'd2,
    ST_FLUSH   = 2'd3
  } state_t;

  localparam logic [CNT_W:0]   LP_DEPTH = DEPTH[CNT_W:0];
  localparam logic [CNT_W-1:0] LP_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_len_q;
  logic [CNT_W-1:0]  r_wr_cnt;
  logic [CNT_W-1:0]  r_level;
  logic [CNT_W-1:0]  w_level_nxt;
  logic [DATA_W-1:0] r_fifo_data;
  logic              r_fifo_wrreq;
  logic              w_in_window;
  logic              w_room;
  logic              w_accept;
  logic              w_refuse;
  logic              w_rdreq;
  logic              w_rd_eff;
  logic              w_arm;

  // A write issued last cycle is not yet in r_level, so it must count against the room.
  assign w_in_window = (r_state == ST_CAPTURE) && io_bus.src_valid && (r_wr_cnt < r_len_q);
  assign w_room      = ({1'b0, r_level} + {{CNT_W{1'b0}}, r_fifo_wrreq}) < LP_DEPTH;
  assign w_accept    = w_in_window && w_room;
  assign w_refuse    = w_in_window && !w_room;

  assign w_rdreq     = io_bus.host_rd || ((r_state == ST_FLUSH) && (r_level != '0));
  assign w_rd_eff    = w_rdreq && (r_level != '0);
  assign w_level_nxt = r_level
                     + {{(CNT_W-1){1'b0}}, r_fifo_wrreq}
                     - {{(CNT_W-1){1'b0}}, w_rd_eff};

  assign w_arm = (r_state == ST_IDLE) && io_bus.start && !io_bus.abort
               && (io_bus.frame_len != '0);

  always_ff @(posedge i_wrclock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (io_bus.abort) begin
      w_state_nxt = ST_FLUSH;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_arm) begin
            w_state_nxt = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          // wr_cnt reaching len_q coincides with the final fifo_wrreq being on the bus.
          if (r_wr_cnt == r_len_q) begin
            w_state_nxt = ST_READY;
          end
        end
        ST_READY: begin
          if (w_level_nxt == '0) begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_FLUSH: begin
          if (r_level == '0) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_wrclock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_fifo_wrreq <= 1'b0;
      r_fifo_data  <= '0;
      r_level      <= '0;
      r_len_q      <= '0;
      r_wr_cnt     <= '0;
    end else begin
      r_fifo_wrreq <= w_accept;
      r_level      <= w_level_nxt;
      if (w_accept) begin
        r_fifo_data <= io_bus.src_data;
      end
      if (w_arm) begin
        r_len_q  <= io_bus.frame_len;
        r_wr_cnt <= '0;
      end else if (w_accept) begin
        r_wr_cnt <= r_wr_cnt + LP_ONE;
      end
    end
  end

`ifdef FIFO_RES_OVF_COUNT_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge i_wrclock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_drop_cnt <= '0;
    end else if (w_arm) begin
      r_drop_cnt <= '0;
    end else if (w_refuse && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign io_bus.drop_cnt = r_drop_cnt;
  assign io_bus.dropped  = (r_drop_cnt != 16'd0);
`else
  logic r_dropped;

  always_ff @(posedge i_wrclock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_dropped <= 1'b0;
    end else if (w_arm) begin
      r_dropped <= 1'b0;
    end else if (w_refuse) begin
      r_dropped <= 1'b1;
    end
  end

  assign io_bus.dropped = r_dropped;
`endif

  assign io_bus.fifo_data   = r_fifo_data;
  assign io_bus.fifo_wrreq  = r_fifo_wrreq;
  assign io_bus.fifo_rdreq  = w_rdreq;
  assign io_bus.busy        = (r_state != ST_IDLE);
  assign io_bus.frame_ready = (r_state == ST_READY);
  assign io_bus.level       = r_level;
endmodule
